fetch_sequencer: RTL and testbench

Program-counter and instruction-register stage directly upstream of instr_fetch decode. Sequences addresses into a synchronous instruction ROM and captures each 9-bit word. Presents the word with a valid flag and its PC to decode. Owns start, halt, branch redirect (squash) and stall.

---
 rtl/fetch_sequencer_pkg.sv | 34 +++
 rtl/fetch_sequencer_pc_reg.sv | 24 ++
 rtl/fetch_sequencer.sv | 102 ++++++++++
 tb/tb_fetch_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: widths, opcode map
// and fetch FSM states, plus an opcode extraction helper.
package fetch_sequencer_pkg;

   localparam int PC_W       = 8;
   localparam int INSTR_W    = 9;
   localparam int OPCODE_MSB = 8;
   localparam int OPCODE_LSB = 4;

   typedef enum logic [4:0] {
      kADD = 5'b00000,
      kSUB = 5'b00001,
      kAND = 5'b00010,
      kOR  = 5'b00011,
      kXOR = 5'b00100,
      kLDI = 5'b00101,
      kLD  = 5'b00110,
      kST  = 5'b00111,
      kBRH = 5'b01000,
      kHLT = 5'b11111
   } op_mne;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } fetch_state_t;

   function automatic logic [4:0] opcode_of(
      input logic [INSTR_W-1:0] word
   );
      return word[OPCODE_MSB:OPCODE_LSB];
   endfunction

endpackage

// File: rtl/fetch_sequencer_pc_reg.sv
// Fetch program counter: load has priority over increment, else hold.
// Ports: CLK, RESET_N, load_en, load_val, inc_en in; pc out.
module pc_reg
   import fetch_sequencer_pkg::*;
(
   input  logic            CLK,
   input  logic            RESET_N,
   input  logic            load_en,
   input  logic [PC_W-1:0] load_val,
   input  logic            inc_en,
   output logic [PC_W-1:0] pc
);

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         pc <= '0;
      end else if (load_en) begin
         pc <= load_val;
      end else if (inc_en) begin
         pc <= pc + PC_W'(1);
      end
   end

endmodule

// File: rtl/fetch_sequencer.sv
// PC / instruction register stage feeding decode from a sync ROM.
// Ports: CLK, RESET_N, START, STARTADDRESS, IMEM_DATA, BRANCH_TAKEN,
// BRANCH_TARGET, STALL in; IMEM_ADDR, IMEM_EN, INSTR_OUT,
// INSTR_VALID, PC_OUT, BUSY, DONE out.
module fetch_sequencer
   import fetch_sequencer_pkg::*;
(
   input  logic               CLK,
   input  logic               RESET_N,
   input  logic               START,
   input  logic [PC_W-1:0]    STARTADDRESS,
   output logic [PC_W-1:0]    IMEM_ADDR,
   output logic               IMEM_EN,
   input  logic [INSTR_W-1:0] IMEM_DATA,
   input  logic               BRANCH_TAKEN,
   input  logic [PC_W-1:0]    BRANCH_TARGET,
   input  logic               STALL,
   output logic [INSTR_W-1:0] INSTR_OUT,
   output logic               INSTR_VALID,
   output logic [PC_W-1:0]    PC_OUT,
   output logic               BUSY,
   output logic               DONE
);

   fetch_state_t    state;
   logic            pend;
   logic [PC_W-1:0] pend_pc;
   logic [PC_W-1:0] fetch_pc;
   logic            run;
   logic            go;
   logic            halt;
   logic            load_en;
   logic            inc_en;
   logic [PC_W-1:0] load_val;

   assign run  = (state == RUN);
   assign go   = run && !STALL;
   // pend marks that IMEM_DATA holds the word fetched last edge
   assign halt = pend && (opcode_of(IMEM_DATA) == kHLT);

   assign load_en  = (!run && START) || (go && BRANCH_TAKEN);
   assign load_val = run ? BRANCH_TARGET : STARTADDRESS;
   assign inc_en   = go && !BRANCH_TAKEN && !halt;

   pc_reg u_pc_reg (
      .CLK      (CLK),
      .RESET_N  (RESET_N),
      .load_en  (load_en),
      .load_val (load_val),
      .inc_en   (inc_en),
      .pc       (fetch_pc)
   );

   assign IMEM_ADDR = fetch_pc;
   assign IMEM_EN   = go;
   assign BUSY      = run;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state       <= IDLE;
         pend        <= 1'b0;
         pend_pc     <= '0;
         INSTR_OUT   <= '0;
         INSTR_VALID <= 1'b0;
         PC_OUT      <= '0;
         DONE        <= 1'b0;
      end else begin
         DONE <= 1'b0;
         if (!run) begin
            if (START) begin
               state       <= RUN;
               pend        <= 1'b0;
               INSTR_VALID <= 1'b0;
            end
         end else if (!STALL) begin
            // branch beats halt: a halt word behind a branch is squashed
            priority case (1'b1)
               BRANCH_TAKEN: begin
                  pend        <= 1'b0;
                  INSTR_VALID <= 1'b0;
               end
               halt: begin
                  pend        <= 1'b0;
                  INSTR_VALID <= 1'b0;
                  state       <= IDLE;
                  DONE        <= 1'b1;
               end
               default: begin
                  pend        <= 1'b1;
                  pend_pc     <= fetch_pc;
                  INSTR_VALID <= pend;
                  if (pend) begin
                     INSTR_OUT <= IMEM_DATA;
                     PC_OUT    <= pend_pc;
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer: directed scenarios plus random
// traffic, checked every cycle against a delivery-order model.
module tb_fetch_sequencer;

   localparam logic [4:0] HLT_OP = 5'b11111;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [7:0] sa;
   logic [7:0] imem_addr;
   logic       imem_en;
   logic [8:0] imem_data;
   logic       branch;
   logic [7:0] tgt;
   logic       stall;
   logic [8:0] instr_out;
   logic       instr_valid;
   logic [7:0] pc_out;
   logic       busy;
   logic       done;

   logic [8:0] rom [256];

   int n_checks = 0;
   int n_errors = 0;

   fetch_sequencer dut (
      .CLK           (clk),
      .RESET_N       (rst_n),
      .START         (start),
      .STARTADDRESS  (sa),
      .IMEM_ADDR     (imem_addr),
      .IMEM_EN       (imem_en),
      .IMEM_DATA     (imem_data),
      .BRANCH_TAKEN  (branch),
      .BRANCH_TARGET (tgt),
      .STALL         (stall),
      .INSTR_OUT     (instr_out),
      .INSTR_VALID   (instr_valid),
      .PC_OUT        (pc_out),
      .BUSY          (busy),
      .DONE          (done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // synchronous ROM, holds its output while disabled
   always @(posedge clk) begin
      if (imem_en) imem_data <= rom[imem_addr];
   end

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  name, got, exp, $time);
      end
   endtask

   // Model: m_next is the next address to be delivered to decode,
   // m_wait the bubbles still owed before it can be delivered.
   logic       m_busy;
   logic       m_valid;
   logic       m_done;
   logic [8:0] m_instr;
   logic [7:0] m_pc;
   logic [7:0] m_next;
   logic [7:0] m_iaddr;
   int         m_wait;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy  <= 1'b0;
         m_valid <= 1'b0;
         m_done  <= 1'b0;
         m_instr <= '0;
         m_pc    <= '0;
         m_next  <= '0;
         m_iaddr <= '0;
         m_wait  <= 0;
      end else begin
         m_done <= 1'b0;
         if (!m_busy) begin
            if (start) begin
               m_busy  <= 1'b1;
               m_valid <= 1'b0;
               m_next  <= sa;
               m_iaddr <= sa;
               m_wait  <= 1;
            end
         end else if (!stall) begin
            if (branch) begin
               m_valid <= 1'b0;
               m_next  <= tgt;
               m_iaddr <= tgt;
               m_wait  <= 1;
            end else if (m_wait > 0) begin
               m_valid <= 1'b0;
               m_wait  <= m_wait - 1;
               m_iaddr <= m_iaddr + 8'd1;
            end else if (rom[m_next][8:4] == HLT_OP) begin
               m_valid <= 1'b0;
               m_busy  <= 1'b0;
               m_done  <= 1'b1;
            end else begin
               m_valid <= 1'b1;
               m_instr <= rom[m_next];
               m_pc    <= m_next;
               m_next  <= m_next + 8'd1;
               m_iaddr <= m_iaddr + 8'd1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         chk("valid", 32'(instr_valid), 32'(m_valid));
         chk("instr", 32'(instr_out), 32'(m_instr));
         chk("pc", 32'(pc_out), 32'(m_pc));
         chk("busy", 32'(busy), 32'(m_busy));
         chk("done", 32'(done), 32'(m_done));
         chk("imem_en", 32'(imem_en), 32'(m_busy && !stall));
         chk("imem_addr", 32'(imem_addr), 32'(m_iaddr));
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic chk_out(input string name, input logic v,
                          input logic [8:0] ins, input logic [7:0] p);
      chk({name, "_valid"}, 32'(instr_valid), 32'(v));
      if (v) begin
         chk({name, "_instr"}, 32'(instr_out), 32'(ins));
         chk({name, "_pc"}, 32'(pc_out), 32'(p));
      end
   endtask

   task automatic chk_zero(input string name);
      chk({name, "_busy"}, 32'(busy), 0);
      chk({name, "_en"}, 32'(imem_en), 0);
      chk({name, "_addr"}, 32'(imem_addr), 0);
      chk({name, "_instr"}, 32'(instr_out), 0);
      chk({name, "_valid"}, 32'(instr_valid), 0);
      chk({name, "_pc"}, 32'(pc_out), 0);
      chk({name, "_done"}, 32'(done), 0);
   endtask

   initial begin
      rst_n  = 1'b0;
      start  = 1'b0;
      sa     = '0;
      branch = 1'b0;
      tgt    = '0;
      stall  = 1'b0;
      for (int i = 0; i < 256; i++) rom[i] = 9'($urandom_range(0, 495));
      rom[8'h10] = 9'h0A3;
      rom[8'h11] = 9'h1C5;
      rom[8'h40] = 9'h07E;
      rom[8'h15] = {HLT_OP, 4'b0000};

      step();
      step();
      chk_zero("reset");
      rst_n = 1'b1;
      step();

      // start at 0x10: two-cycle fill latency
      start = 1'b1;
      sa    = 8'h10;
      step();
      start = 1'b0;
      chk("start_busy", 32'(busy), 1);
      chk_out("fill1", 1'b0, '0, '0);
      step();
      chk_out("fill2", 1'b0, '0, '0);
      step();
      chk_out("first", 1'b1, 9'h0A3, 8'h10);
      step();
      chk_out("second", 1'b1, 9'h1C5, 8'h11);
      step();
      chk_out("third", 1'b1, rom[8'h12], 8'h12);

      // branch to 0x40: two bubbles
      branch = 1'b1;
      tgt    = 8'h40;
      step();
      branch = 1'b0;
      chk_out("br_b1", 1'b0, '0, '0);
      step();
      chk_out("br_b2", 1'b0, '0, '0);
      step();
      chk_out("br_tgt", 1'b1, 9'h07E, 8'h40);

      // reach 0x20, then stall three cycles
      branch = 1'b1;
      tgt    = 8'h20;
      step();
      branch = 1'b0;
      step();
      step();
      chk_out("at20", 1'b1, rom[8'h20], 8'h20);
      stall = 1'b1;
      #1;
      chk("stall_en", 32'(imem_en), 0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk_out("stall_hold", 1'b1, rom[8'h20], 8'h20);
      end
      stall = 1'b0;
      step();
      chk_out("post21", 1'b1, rom[8'h21], 8'h21);
      step();
      chk_out("post22", 1'b1, rom[8'h22], 8'h22);

      // halt word at 0x15
      branch = 1'b1;
      tgt    = 8'h14;
      step();
      branch = 1'b0;
      step();
      step();
      chk_out("at14", 1'b1, rom[8'h14], 8'h14);
      step();
      chk("halt_done", 32'(done), 1);
      chk("halt_busy", 32'(busy), 0);
      chk("halt_valid", 32'(instr_valid), 0);
      step();
      chk("done_pulse", 32'(done), 0);

      // restart at 0x00
      start = 1'b1;
      sa    = 8'h00;
      step();
      start = 1'b0;
      step();
      step();
      chk_out("restart", 1'b1, rom[8'h00], 8'h00);

      // branch straight onto the halt word
      branch = 1'b1;
      tgt    = 8'h15;
      step();
      branch = 1'b0;
      step();
      step();
      chk("halt2_done", 32'(done), 1);

      // wrap FE, FF, 00, 01
      start = 1'b1;
      sa    = 8'hFE;
      step();
      start = 1'b0;
      step();
      step();
      chk_out("wrapFE", 1'b1, rom[8'hFE], 8'hFE);
      step();
      chk_out("wrapFF", 1'b1, rom[8'hFF], 8'hFF);
      step();
      chk_out("wrap00", 1'b1, rom[8'h00], 8'h00);
      step();
      chk_out("wrap01", 1'b1, rom[8'h01], 8'h01);

      // asynchronous reset between edges
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk_zero("async_rst");
      step();
      step();
      rst_n = 1'b1;
      step();

      // START while running is ignored
      start = 1'b1;
      sa    = 8'h30;
      step();
      start = 1'b0;
      step();
      step();
      chk_out("run30", 1'b1, rom[8'h30], 8'h30);
      start = 1'b1;
      sa    = 8'h80;
      step();
      chk_out("run31", 1'b1, rom[8'h31], 8'h31);
      step();
      chk_out("run32", 1'b1, rom[8'h32], 8'h32);
      start = 1'b0;
      step();
      chk_out("run33", 1'b1, rom[8'h33], 8'h33);

      // random traffic with halts sprinkled through the ROM
      rst_n = 1'b0;
      step();
      for (int i = 0; i < 256; i++) begin
         if ($urandom_range(0, 15) == 0)
            rom[i] = {HLT_OP, 4'($urandom)};
         else
            rom[i] = 9'($urandom_range(0, 495));
      end
      rst_n = 1'b1;
      step();
      for (int c = 0; c < 3000; c++) begin
         start  = ($urandom_range(0, 3) == 0);
         sa     = 8'($urandom);
         stall  = ($urandom_range(0, 4) == 0);
         branch = ($urandom_range(0, 7) == 0);
         tgt    = 8'($urandom);
         step();
      end
      start  = 1'b0;
      stall  = 1'b0;
      branch = 1'b0;
      step();

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
